move_collector: RTL
===================

// Module: move_collector
// PURPOSE
//  Board-level stage directly downstream of the eight column units. Drains each column's
//  152-bit move FIFO, where one word holds 8 slots of 19 bits. Unpacks the words into single
//  19-bit moves, drops slots marked invalid, and streams the moves out over valid/ready.
//  Raises all_done once every column is done, every column FIFO is empty, and the last move
//  has been accepted.
// PARAMETERS
//  NCOL    8    number of column units (one per file a..h)
//  SLOTS   8    move slots per column FIFO word
//  MOVE_W  19   move width: [7b flag][6b from][6b to]; flag[6]=bit 18=invalid
//  CNT_W   8    width of the emitted-move counter
// PORTS
//  clk         in   1                  system clock, rising edge
//  reset       in   1                  asynchronous, active-high; clears all state
//  start       in   1                  1-cycle pulse: begin a new collection pass
//  col_done    in   NCOL               per-column done flags
//  col_empty   in   NCOL               per-column FIFO empty flags
//  col_data    in   NCOL*SLOTS*MOVE_W  column FIFO read data; column c = [c*152 +: 152]
//  col_rden    out  NCOL               one-hot FIFO read enable, 1-cycle pulse
//  move_out    out  MOVE_W             current move; slot s of a word = [s*19 +: 19]
//  move_valid  out  1                  move_out is valid
//  move_ready  in   1                  consumer accepts move_out when valid&ready
//  move_count  out  CNT_W              moves emitted in this pass; saturates at 255
//  all_done    out  1                  collection pass complete
// BEHAVIOUR
//  Reset values: col_rden=0, move_out=0, move_valid=0, move_count=0, all_done=0.
//    Internal: state=IDLE, rr_ptr=0, slot_mask=0.
//  FSM states: IDLE, SCAN, READ, LATCH, EMIT, FIN.
//  IDLE: wait for start. On start, clear move_count and all_done, then go to SCAN.
//  SCAN: round-robin search for the first column c with ~col_empty[c].
//    Search starts at rr_ptr and wraps from NCOL-1 to 0.
//    Column found: col_rden[c]=1 for exactly one cycle, rr_ptr<=c+1 (mod NCOL), go to READ.
//    No column found and &(col_done & col_empty): go to FIN.
//    Otherwise: stay in SCAN. A column can be non-done and empty; this is not an error.
//  READ: wait one cycle. Column FIFO read latency is 1 cycle, data is valid in LATCH.
//  LATCH: capture the 152-bit word.
//    slot_mask[s] = ~word[s*19+18], i.e. slot s is kept when its invalid bit is clear.
//    slot_mask == 0: back to SCAN. Otherwise go to EMIT.
//  EMIT: move_out = lowest set slot of slot_mask (priority encoder).
//    Invalid slots are skipped with no bubble cycle.
//    move_valid stays high, and move_out stays stable, until move_ready is seen.
//    On handshake: clear that slot bit, move_count+1 unless already 255.
//    When the last bit clears: move_valid drops next cycle, then SCAN.
//    Back-to-back handshakes, one per cycle, are required.
//  FIN: all_done=1 and held until the next start or reset.
//  start while busy (any state except IDLE/FIN): abort the pass.
//    The buffered word is discarded and move_valid drops next cycle.
//    Counter cleared, rr_ptr=0, go to SCAN.
//  start and move_ready in the same cycle: start wins; the move is not counted.
//  Reset asserted mid-pass: async clear of all outputs. Column FIFOs are not flushed by
//    this block.
//  move_count saturates: 255+1 stays 255.
//  rr_ptr wraps: next column after 7 is 0.
// STRUCTURE
//  Shared package (chess_pkg): MOVE_W, SLOTS, NCOL and the flag bit indices
//    (FLG_INVALID=18, FLG_PROMOTE=17, FLG_PAWN=16, FLG_PAWN2=15, FLG_EP=14,
//    FLG_CASTLE=13, FLG_CAPTURE=12). FSM state encodings are local.
//  One sub-module: rr_arbiter (NCOL-bit request vector + pointer -> one-hot grant + index).
//    Reused later by the board-level evaluator.
//  The slot priority encoder is inline combinational logic.
// TESTING
//  1. One column (c=3) holds one word with slots 0,2,7 valid, all columns done.
//     start -> exactly 3 moves in slot order 0,2,7; move_count=3; all_done=1.
//  2. Columns 1 and 6 each hold one word, rr_ptr=0.
//     -> col_rden pulses for column 1 before column 6. Next pass with rr_ptr=2 and
//     both columns loaded again: column 6 is served first.
//  3. move_ready held low for 5 cycles in EMIT.
//     -> move_valid stays high and move_out stays stable; move_count does not change.
//  4. Word with all 8 slot invalid bits set.
//     -> no move_valid; FSM returns to SCAN; move_count=0.
//  5. 33 full words (264 moves) spread across the columns.
//     -> move_count saturates at 255; all 264 moves are still emitted.
//  6. reset asserted during EMIT, then start pulsed during an active pass.
//     -> outputs clear immediately (async); the restart gives move_count=0 and
//     move_valid=0 the next cycle.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess datapath constants: board geometry, move word layout and move flag bits.
package chess_pkg;

    localparam int unsigned NCOL   = 8;
    localparam int unsigned SLOTS  = 8;
    localparam int unsigned MOVE_W = 19;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WORD_W = SLOTS * MOVE_W;
    localparam int unsigned COL_W  = $clog2(NCOL);

    // Move layout: [18:12] flags, [11:6] from square, [5:0] to square
    localparam int unsigned FLG_INVALID = 18;
    localparam int unsigned FLG_PROMOTE = 17;
    localparam int unsigned FLG_PAWN    = 16;
    localparam int unsigned FLG_PAWN2   = 15;
    localparam int unsigned FLG_EP      = 14;
    localparam int unsigned FLG_CASTLE  = 13;
    localparam int unsigned FLG_CAPTURE = 12;

    typedef struct packed {
        logic [6:0] flag;
        logic [5:0] from_sq;
        logic [5:0] to_sq;
    } move_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
    parameter int unsigned N = 8,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= int'(N)) begin
                pos = pos - int'(N);
            end
            if (req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
                gnt   = N'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/move_collector.sv
// Drains the column move FIFOs round-robin, unpacks each word into valid moves and
// streams them out over valid/ready; flags all_done when every column is exhausted.
module move_collector
    import chess_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NCOL-1:0]          col_done,
    input  logic [NCOL-1:0]          col_empty,
    input  logic [NCOL*WORD_W-1:0]   col_data,
    output logic [NCOL-1:0]          col_rden,
    output logic [MOVE_W-1:0]        move_out,
    output logic                     move_valid,
    input  logic                     move_ready,
    output logic [CNT_W-1:0]         move_count,
    output logic                     all_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_READ, S_LATCH, S_EMIT, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [COL_W-1:0]    col_sel_q, col_sel_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SLOTS-1:0]    slot_mask_q, slot_mask_d;
    logic [NCOL-1:0]     col_rden_q, col_rden_d;
    logic [MOVE_W-1:0]   move_out_q, move_out_d;
    logic                move_valid_q, move_valid_d;
    logic [CNT_W-1:0]    move_count_q, move_count_d;
    logic                all_done_q, all_done_d;

    logic [NCOL-1:0]     arb_gnt;
    logic [COL_W-1:0]    arb_idx;
    logic                arb_found;
    logic [NCOL-1:0]     col_req;

    logic [WORD_W-1:0]   col_words [NCOL];
    logic [WORD_W-1:0]   latch_word;
    logic [SLOTS-1:0]    latch_mask;
    logic [SLOTS-1:0]    rem_mask;
    logic [SLOTS-1:0]    enc_mask;
    logic [WORD_W-1:0]   enc_word;
    logic [MOVE_W-1:0]   enc_move;
    logic                handshake;
    logic                busy;

    assign col_req = ~col_empty;

    rr_arbiter #(.N(NCOL)) u_arb (
        .req   (col_req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    always_comb begin
        for (int c = 0; c < int'(NCOL); c++) begin
            col_words[c] = col_data[c*WORD_W +: WORD_W];
        end
    end

    // Slot unpack and lowest-set-slot priority encoder, shared by LATCH and EMIT.
    always_comb begin
        latch_word = col_words[col_sel_q];
        for (int s = 0; s < int'(SLOTS); s++) begin
            latch_mask[s] = ~latch_word[s*MOVE_W + FLG_INVALID];
        end
        rem_mask = slot_mask_q & (slot_mask_q - SLOTS'(1));
        enc_mask = (state_q == S_LATCH) ? latch_mask : rem_mask;
        enc_word = (state_q == S_LATCH) ? latch_word : word_q;
        enc_move = '0;
        for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
            if (enc_mask[s]) begin
                enc_move = enc_word[s*MOVE_W +: MOVE_W];
            end
        end
    end

    assign handshake = move_valid_q & move_ready;
    assign busy      = (state_q == S_SCAN) || (state_q == S_READ) ||
                       (state_q == S_LATCH) || (state_q == S_EMIT);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        col_sel_d    = col_sel_q;
        word_d       = word_q;
        slot_mask_d  = slot_mask_q;
        col_rden_d   = '0;
        move_out_d   = move_out_q;
        move_valid_d = move_valid_q;
        move_count_d = move_count_q;
        all_done_d   = all_done_q;

        case (state_q)
            S_SCAN: begin
                if (arb_found) begin
                    col_rden_d = arb_gnt;
                    col_sel_d  = arb_idx;
                    rr_ptr_d   = (arb_idx == COL_W'(NCOL - 1)) ? '0 : arb_idx + COL_W'(1);
                    state_d    = S_READ;
                end else if (&(col_done & col_empty)) begin
                    all_done_d = 1'b1;
                    state_d    = S_FIN;
                end
            end
            S_READ: state_d = S_LATCH;
            S_LATCH: begin
                word_d      = latch_word;
                slot_mask_d = latch_mask;
                if (latch_mask == '0) begin
                    state_d = S_SCAN;
                end else begin
                    move_out_d   = enc_move;
                    move_valid_d = 1'b1;
                    state_d      = S_EMIT;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    slot_mask_d  = rem_mask;
                    move_count_d = (move_count_q == {CNT_W{1'b1}}) ? move_count_q
                                                                   : move_count_q + CNT_W'(1);
                    if (rem_mask == '0) begin
                        move_valid_d = 1'b0;
                        state_d      = S_SCAN;
                    end else begin
                        move_out_d = enc_move;
                    end
                end
            end
            default: ;
        endcase

        // A start in any state begins a fresh pass; mid-pass it also rewinds the pointer.
        if (start) begin
            col_rden_d   = '0;
            slot_mask_d  = '0;
            move_valid_d = 1'b0;
            move_count_d = '0;
            all_done_d   = 1'b0;
            state_d      = S_SCAN;
            if (busy) begin
                rr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            col_sel_q    <= '0;
            word_q       <= '0;
            slot_mask_q  <= '0;
            col_rden_q   <= '0;
            move_out_q   <= '0;
            move_valid_q <= 1'b0;
            move_count_q <= '0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            col_sel_q    <= col_sel_d;
            word_q       <= word_d;
            slot_mask_q  <= slot_mask_d;
            col_rden_q   <= col_rden_d;
            move_out_q   <= move_out_d;
            move_valid_q <= move_valid_d;
            move_count_q <= move_count_d;
            all_done_q   <= all_done_d;
        end
    end

    assign col_rden   = col_rden_q;
    assign move_out   = move_out_q;
    assign move_valid = move_valid_q;
    assign move_count = move_count_q;
    assign all_done   = all_done_q;

endmodule
